// File: rtl/mips_cpu_bus_arbiter_lsu_if.sv
// Avalon-MM master/slave bundle used by the MIPS bus arbiter/LSU.
interface mips_cpu_bus_arbiter_lsu_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_bus_arbiter_lsu.sv
// Shared Avalon-MM master for the multicycle MIPS core: fetch/data arbitration,
// lane steering, load extension and stall counting. Define MIPS_BUS_ALIGN_CHECK_EN
// to reject misaligned half/word data accesses with d_err instead of issuing them.
module mips_cpu_bus_arbiter_lsu #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            if_req,
  input  logic [31:0]                     if_addr,
  output logic                            if_ack,
  output logic [31:0]                     if_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [31:0]                     d_addr,
  input  logic [1:0]                      d_size,
  input  logic                            d_signed,
  input  logic [31:0]                     d_wdata,
  output logic                            d_ack,
  output logic [31:0]                     d_rdata,
  output logic                            d_err,
  mips_cpu_bus_arbiter_lsu_if.master      bus,
  output logic [CNT_W-1:0]                stall_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_nxt;
  logic              cap_d, cap_d_nxt;
  logic              cap_we, cap_we_nxt;
  logic [1:0]        cap_size, cap_size_nxt;
  logic              cap_signed, cap_signed_nxt;
  logic [1:0]        cap_lane, cap_lane_nxt;
  logic              rr_favor_d, rr_favor_d_nxt;

  logic [31:0]       address_nxt;
  logic              read_nxt, write_nxt;
  logic [DATA_W-1:0] writedata_nxt;
  logic [BE_W-1:0]   byteenable_nxt;
  logic              if_ack_nxt, d_ack_nxt, d_err_nxt;
  logic [31:0]       if_rdata_nxt, d_rdata_nxt;
  logic [CNT_W-1:0]  stall_nxt;

  logic              any_req_c;
  logic              pick_d_c;
  logic [31:0]       sel_addr_c;
  logic              misalign_c;

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    lane_be = 4'b0001 << lane;
      2'd1:    lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] steer_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    steer_wdata = {4{wd[7:0]}};
      2'd1:    steer_wdata = {2{wd[15:0]}};
      default: steer_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    load_ext = {{24{sgn & b[7]}}, b};
      2'd1:    load_ext = {{16{sgn & h[15]}}, h};
      default: load_ext = rd;
    endcase
  endfunction

  // Data wins ties in fixed mode; in round-robin the port not granted last wins.
  assign any_req_c  = if_req | d_req;
  assign pick_d_c   = d_req & (~if_req | (ARB_MODE == 0) | rr_favor_d);
  assign sel_addr_c = pick_d_c ? d_addr : if_addr;
  assign misalign_c = ALIGN_CHECK & pick_d_c &
                      (((d_size == 2'd1) & d_addr[0]) | (d_size[1] & (d_addr[1:0] != 2'd0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cap_d          <= 1'b0;
      cap_we         <= 1'b0;
      cap_size       <= 2'd0;
      cap_signed     <= 1'b0;
      cap_lane       <= 2'd0;
      rr_favor_d     <= 1'b1;
      bus.address    <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      stall_count    <= '0;
    end else begin
      state          <= state_nxt;
      cap_d          <= cap_d_nxt;
      cap_we         <= cap_we_nxt;
      cap_size       <= cap_size_nxt;
      cap_signed     <= cap_signed_nxt;
      cap_lane       <= cap_lane_nxt;
      rr_favor_d     <= rr_favor_d_nxt;
      bus.address    <= address_nxt;
      bus.read       <= read_nxt;
      bus.write      <= write_nxt;
      bus.writedata  <= writedata_nxt;
      bus.byteenable <= byteenable_nxt;
      if_ack         <= if_ack_nxt;
      d_ack          <= d_ack_nxt;
      d_err          <= d_err_nxt;
      if_rdata       <= if_rdata_nxt;
      d_rdata        <= d_rdata_nxt;
      stall_count    <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req_c) state_nxt = misalign_c ? RESP : BUS;
      BUS:  if (!bus.waitrequest) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_d_nxt      = cap_d;
    cap_we_nxt     = cap_we;
    cap_size_nxt   = cap_size;
    cap_signed_nxt = cap_signed;
    cap_lane_nxt   = cap_lane;
    rr_favor_d_nxt = rr_favor_d;
    address_nxt    = bus.address;
    read_nxt       = bus.read;
    write_nxt      = bus.write;
    writedata_nxt  = bus.writedata;
    byteenable_nxt = bus.byteenable;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    d_err_nxt      = 1'b0;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    stall_nxt      = stall_count;
    case (state)
      IDLE: begin
        if (any_req_c) begin
          cap_d_nxt      = pick_d_c;
          cap_we_nxt     = pick_d_c & d_we;
          cap_size_nxt   = pick_d_c ? d_size : 2'd2;
          cap_signed_nxt = d_signed;
          cap_lane_nxt   = sel_addr_c[1:0];
          rr_favor_d_nxt = ~pick_d_c;
          if (misalign_c) begin
            d_ack_nxt   = 1'b1;
            d_err_nxt   = 1'b1;
            d_rdata_nxt = '0;
          end else begin
            address_nxt    = {sel_addr_c[31:2], 2'b00};
            read_nxt       = ~(pick_d_c & d_we);
            write_nxt      = pick_d_c & d_we;
            byteenable_nxt = lane_be(pick_d_c ? d_size : 2'd2, sel_addr_c[1:0]);
            if (pick_d_c & d_we) writedata_nxt = steer_wdata(d_size, d_wdata);
          end
        end
      end
      BUS: begin
        if (bus.waitrequest) begin
          if (stall_count != {CNT_W{1'b1}}) stall_nxt = stall_count + CNT_W'(1);
        end else begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (cap_d) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = cap_we ? 32'h0 : load_ext(bus.readdata, cap_size, cap_lane, cap_signed);
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = bus.readdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter_lsu.sv
// Directed bench for mips_cpu_bus_arbiter_lsu; u0 is fixed priority, u1 round-robin.
module tb_mips_cpu_bus_arbiter_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, d_signed;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        wr;
  logic [31:0] rd;

  logic        if_ack0, d_ack0, d_err0, if_ack1, d_ack1, d_err1;
  logic [31:0] if_rdata0, d_rdata0, if_rdata1, d_rdata1;
  logic [15:0] stall0, stall1;

  int checks   = 0;
  int failures = 0;

  mips_cpu_bus_arbiter_lsu_if b0 ();
  mips_cpu_bus_arbiter_lsu_if b1 ();
  assign b0.waitrequest = wr;
  assign b1.waitrequest = wr;
  assign b0.readdata    = rd;
  assign b1.readdata    = rd;

  mips_cpu_bus_arbiter_lsu #(.ARB_MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack0),
    .if_rdata(if_rdata0), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(d_ack0), .d_rdata(d_rdata0),
    .d_err(d_err0), .bus(b0.master), .stall_count(stall0));

  mips_cpu_bus_arbiter_lsu #(.ARB_MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1),
    .if_rdata(if_rdata1), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(d_ack1), .d_rdata(d_rdata1),
    .d_err(d_err1), .bus(b1.master), .stall_count(stall1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0; d_signed = 0; d_size = 2'd0;
    if_addr = '0; d_addr = '0; d_wdata = '0; wr = 0; rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if ({b0.read, b0.write, if_ack0, d_ack0, d_err0} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {b0.read, b0.write, if_ack0, d_ack0, d_err0}); end
    checks++; if (b0.address !== 32'h0 || b0.writedata !== 32'h0 || b0.byteenable !== 4'h0) begin failures++; $display("FAIL reset_bus addr=%h wd=%h be=%b exp=0", b0.address, b0.writedata, b0.byteenable); end
    checks++; if (if_rdata0 !== 32'h0 || d_rdata0 !== 32'h0 || stall0 !== 16'h0) begin failures++; $display("FAIL reset_data ir=%h dr=%h st=%0d exp=0", if_rdata0, d_rdata0, stall0); end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'hBFC00000; wr = 0; rd = 32'h24020005;
    tick();
    checks++; if (b0.read !== 1'b1 || b0.write !== 1'b0 || b0.address !== 32'hBFC00000 || b0.byteenable !== 4'b1111) begin failures++; $display("FAIL fetch_issue rd=%b wr=%b addr=%h be=%b exp 1 0 bfc00000 1111", b0.read, b0.write, b0.address, b0.byteenable); end
    checks++; if (if_ack0 !== 1'b0) begin failures++; $display("FAIL fetch_early_ack got=%b exp=0", if_ack0); end
    tick();
    checks++; if (if_ack0 !== 1'b1 || if_rdata0 !== 32'h24020005 || b0.read !== 1'b0 || d_ack0 !== 1'b0) begin failures++; $display("FAIL fetch_ack ack=%b data=%h read=%b dack=%b exp 1 24020005 0 0", if_ack0, if_rdata0, b0.read, d_ack0); end
    if_req = 0; rd = 32'hDEADBEEF;
    tick();
    checks++; if (if_ack0 !== 1'b0 || if_rdata0 !== 32'h24020005) begin failures++; $display("FAIL fetch_hold ack=%b data=%h exp 0 24020005", if_ack0, if_rdata0); end
  endtask

  task automatic test_byte_load(input logic sgn, input logic [31:0] exp_data, input logic [15:0] exp_stall);
    d_req = 1; d_we = 0; d_addr = 32'h1003; d_size = 2'd0; d_signed = sgn; wr = 1; rd = 32'h80000000;
    tick();
    checks++; if (b0.read !== 1'b1 || b0.byteenable !== 4'b1000 || b0.address !== 32'h1000) begin failures++; $display("FAIL bload_issue read=%b be=%b addr=%h exp 1 1000 00001000", b0.read, b0.byteenable, b0.address); end
    d_signed = ~sgn;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b0.read !== 1'b1 || d_ack0 !== 1'b0 || b0.address !== 32'h1000) begin failures++; $display("FAIL bload_stall%0d read=%b ack=%b addr=%h exp 1 0 00001000", i, b0.read, d_ack0, b0.address); end
    end
    wr = 0;
    tick();
    checks++; if (d_ack0 !== 1'b1 || d_rdata0 !== exp_data || b0.read !== 1'b0) begin failures++; $display("FAIL bload_ack ack=%b data=%h read=%b exp 1 %h 0", d_ack0, d_rdata0, b0.read, exp_data); end
    checks++; if (stall0 !== exp_stall) begin failures++; $display("FAIL bload_stall_count got=%0d exp=%0d", stall0, exp_stall); end
    d_req = 0; d_signed = 0;
    tick();
    checks++; if (d_ack0 !== 1'b0 || d_rdata0 !== exp_data) begin failures++; $display("FAIL bload_hold ack=%b data=%h exp 0 %h", d_ack0, d_rdata0, exp_data); end
  endtask

  task automatic test_half_store();
    d_req = 1; d_we = 1; d_addr = 32'h2002; d_size = 2'd1; d_wdata = 32'h0000BEEF; wr = 0;
    tick();
    checks++; if (b0.write !== 1'b1 || b0.read !== 1'b0 || b0.byteenable !== 4'b1100) begin failures++; $display("FAIL hstore_ctrl write=%b read=%b be=%b exp 1 0 1100", b0.write, b0.read, b0.byteenable); end
    checks++; if (b0.writedata !== 32'hBEEFBEEF || b0.address !== 32'h2000) begin failures++; $display("FAIL hstore_data wd=%h addr=%h exp beefbeef 00002000", b0.writedata, b0.address); end
    d_wdata = 32'h0;
    tick();
    checks++; if (d_ack0 !== 1'b1 || d_rdata0 !== 32'h0 || b0.write !== 1'b0) begin failures++; $display("FAIL hstore_ack ack=%b data=%h write=%b exp 1 0 0", d_ack0, d_rdata0, b0.write); end
    d_req = 0; d_we = 0;
    tick();
  endtask

  task automatic test_arbitration();
    idle_inputs();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if_addr = 32'h4000; d_addr = 32'h5000; d_size = 2'd2; d_we = 0;
      if_req = 1; d_req = 1; wr = 0; rd = 32'hA0 + k;
      tick();
      checks++; if (b0.address !== 32'h5000) begin failures++; $display("FAIL arb_fixed%0d addr=%h exp 00005000", k, b0.address); end
      checks++; if (b1.address !== ((k % 2 == 0) ? 32'h5000 : 32'h4000)) begin failures++; $display("FAIL arb_rr%0d addr=%h exp %h", k, b1.address, (k % 2 == 0) ? 32'h5000 : 32'h4000); end
      tick();
      checks++; if (d_ack0 !== 1'b1 || if_ack0 !== 1'b0) begin failures++; $display("FAIL arb_fixed_ack%0d d=%b i=%b exp 1 0", k, d_ack0, if_ack0); end
      checks++; if ({d_ack1, if_ack1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL arb_rr_ack%0d d/i=%b exp %b", k, {d_ack1, if_ack1}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      if_req = 0; d_req = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h6000; d_size = 2'd2; wr = 1;
    tick(); tick();
    checks++; if (b0.read !== 1'b1 || stall0 !== 16'd1) begin failures++; $display("FAIL rmid_pre read=%b stall=%0d exp 1 1", b0.read, stall0); end
    reset = 1;
    tick();
    reset = 0; d_req = 0; wr = 0;
    checks++; if (b0.read !== 1'b0 || d_ack0 !== 1'b0 || stall0 !== 16'd0 || b0.address !== 32'h0) begin failures++; $display("FAIL rmid_reset read=%b ack=%b stall=%0d addr=%h exp 0 0 0 0", b0.read, d_ack0, stall0, b0.address); end
    tick();
    checks++; if (d_ack0 !== 1'b0 || b0.read !== 1'b0) begin failures++; $display("FAIL rmid_noack ack=%b read=%b exp 0 0", d_ack0, b0.read); end
    if_req = 1; if_addr = 32'h7004; rd = 32'h11112222;
    tick();
    checks++; if (b0.read !== 1'b1 || b0.address !== 32'h7004) begin failures++; $display("FAIL rmid_idle read=%b addr=%h exp 1 00007004", b0.read, b0.address); end
    tick();
    checks++; if (if_ack0 !== 1'b1 || if_rdata0 !== 32'h11112222) begin failures++; $display("FAIL rmid_fetch ack=%b data=%h exp 1 11112222", if_ack0, if_rdata0); end
    if_req = 0;
    tick();
  endtask

  task automatic test_misaligned();
    d_req = 1; d_we = 0; d_addr = 32'h3001; d_size = 2'd2; wr = 0; rd = 32'h12345678;
    tick();
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    checks++; if (b0.read !== 1'b0 || d_ack0 !== 1'b1 || d_err0 !== 1'b1 || d_rdata0 !== 32'h0) begin failures++; $display("FAIL mis_err read=%b ack=%b err=%b data=%h exp 0 1 1 0", b0.read, d_ack0, d_err0, d_rdata0); end
    d_req = 0;
    tick();
    checks++; if (d_ack0 !== 1'b0 || d_err0 !== 1'b0 || b0.read !== 1'b0) begin failures++; $display("FAIL mis_done ack=%b err=%b read=%b exp 0 0 0", d_ack0, d_err0, b0.read); end
`else
    checks++; if (b0.read !== 1'b1 || b0.address !== 32'h3000 || b0.byteenable !== 4'b1111) begin failures++; $display("FAIL mis_issue read=%b addr=%h be=%b exp 1 00003000 1111", b0.read, b0.address, b0.byteenable); end
    d_req = 0;
    tick();
    checks++; if (d_ack0 !== 1'b1 || d_err0 !== 1'b0 || d_rdata0 !== 32'h12345678) begin failures++; $display("FAIL mis_ack ack=%b err=%b data=%h exp 1 0 12345678", d_ack0, d_err0, d_rdata0); end
`endif
    tick();
    checks++; if (stall0 !== 16'd0) begin failures++; $display("FAIL mis_stall got=%0d exp=0", stall0); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_fetch();
    test_byte_load(1'b1, 32'hFFFFFF80, 16'd3);
    test_byte_load(1'b0, 32'h00000080, 16'd6);
    test_half_store();
    test_arbitration();
    test_reset_mid();
    test_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
